// File: rtl/cnn_kernel_ctrl.sv
// cnn_kernel_ctrl: sequencer running one valid-mode, stride-1 convolution through a cnn_kernel.
//   clk, reset_n            : rising-edge clock, asynchronous active-low reset
//   i_start / i_abort       : begin a job (IDLE only) / abandon the current job (any busy state)
//   i_wgt_we / i_wgt_data   : weight load, captured only in IDLE
//   o_busy / o_done         : high outside IDLE / one-cycle completion pulse
//   o_rd_en, o_rd_x, o_rd_y : window read request and top-left corner
//   i_rd_data               : window data, valid one cycle after o_rd_en
//   o_k_soft_reset, o_k_weight, o_k_valid, o_k_fmap : kernel drive
//   i_k_valid, i_k_acc      : kernel result return
//   o_ot_valid, o_ot_data, i_ot_ready : result stream with ready/valid backpressure
module cnn_kernel_ctrl #(
    parameter int IW          = 8,
    parameter int IH          = 8,
    parameter int KX          = 3,
    parameter int KY          = 3,
    parameter int DATA_LEN    = 8,
    parameter int K_LAT       = 2,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic                         i_wgt_we,
    input  logic [KX*KY*DATA_LEN-1:0]    i_wgt_data,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_rd_en,
    output logic [$clog2(IW)-1:0]        o_rd_x,
    output logic [$clog2(IH)-1:0]        o_rd_y,
    input  logic [KX*KY*DATA_LEN-1:0]    i_rd_data,
    output logic                         o_k_soft_reset,
    output logic [KX*KY*DATA_LEN-1:0]    o_k_weight,
    output logic                         o_k_valid,
    output logic [KX*KY*DATA_LEN-1:0]    o_k_fmap,
    input  logic                         i_k_valid,
    input  logic [DATA_LEN-1:0]          i_k_acc,
    output logic                         o_ot_valid,
    output logic [DATA_LEN-1:0]          o_ot_data,
    input  logic                         i_ot_ready
);
    localparam int OW   = IW - KX + 1;
    localparam int OH   = IH - KY + 1;
    localparam int NOUT = OW * OH;
    localparam int VW   = KX * KY * DATA_LEN;
    localparam int XW   = $clog2(IW);
    localparam int YW   = $clog2(IH);
    localparam int CW   = $clog2(NOUT + 1);
    localparam int FW   = $clog2(OFIFO_DEPTH + 1);
    localparam int PW   = $clog2(OFIFO_DEPTH);
    // The credit rule bounds inflight by the FIFO depth as well as the kernel latency.
    localparam int IFW  = $clog2(OFIFO_DEPTH + K_LAT + 2);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                srst_q, srst_d;
    logic                kv_q, kv_d;
    logic [VW-1:0]       wgt_q, wgt_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [CW-1:0]       issued_q, issued_d;
    logic [CW-1:0]       popped_q, popped_d;
    logic [IFW-1:0]      infl_q, infl_d;
    logic [FW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       wp_q, wp_d;
    logic [PW-1:0]       rp_q, rp_d;
    logic [DATA_LEN-1:0] mem_q [OFIFO_DEPTH];
    logic                abort, rd_en, push, pop, x_last;

    always_comb begin
        abort    = i_abort && (state_q != S_IDLE);
        rd_en    = (state_q == S_RUN) && ((int'(cnt_q) + int'(infl_q)) < OFIFO_DEPTH);
        // Results are only accepted while a job is live; stragglers from an aborted job are dropped.
        push     = i_k_valid && ((state_q == S_RUN) || (state_q == S_DRAIN));
        pop      = (cnt_q != '0) && i_ot_ready;
        x_last   = x_q == XW'(OW - 1);
        state_d  = state_q;
        wgt_d    = ((state_q == S_IDLE) && i_wgt_we) ? i_wgt_data : wgt_q;
        x_d      = rd_en ? (x_last ? '0 : x_q + XW'(1)) : x_q;
        y_d      = (rd_en && x_last) ? y_q + YW'(1) : y_q;
        issued_d = issued_q + CW'(rd_en);
        popped_d = popped_q + CW'(pop);
        infl_d   = infl_q + IFW'(rd_en) - IFW'(push);
        cnt_d    = cnt_q + FW'(push) - FW'(pop);
        wp_d     = wp_q + PW'(push);
        rp_d     = rp_q + PW'(pop);
        case (state_q)
            S_IDLE:  state_d = i_start ? S_CLEAR : S_IDLE;
            S_CLEAR: begin
                state_d  = S_RUN;
                x_d      = '0;
                y_d      = '0;
                issued_d = '0;
                popped_d = '0;
                infl_d   = '0;
            end
            S_RUN:   state_d = (rd_en && (issued_q == CW'(NOUT - 1))) ? S_DRAIN : S_RUN;
            // Looking at popped_d lets DONE follow the final pop by exactly one cycle.
            S_DRAIN: state_d = (popped_d == CW'(NOUT)) ? S_DONE : S_DRAIN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            x_d      = '0;
            y_d      = '0;
            issued_d = '0;
            popped_d = '0;
            infl_d   = '0;
            cnt_d    = '0;
            wp_d     = '0;
            rp_d     = '0;
        end
        busy_d = state_d != S_IDLE;
        done_d = state_d == S_DONE;
        srst_d = (state_d == S_CLEAR) || abort;
        // A read issued in the abort cycle is never forwarded to the kernel.
        kv_d   = rd_en && !abort;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            srst_q   <= 1'b0;
            kv_q     <= 1'b0;
            wgt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            issued_q <= '0;
            popped_q <= '0;
            infl_q   <= '0;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            for (int i = 0; i < OFIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            srst_q   <= srst_d;
            kv_q     <= kv_d;
            wgt_q    <= wgt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            infl_q   <= infl_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            if (push) mem_q[wp_q] <= i_k_acc;
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(i_k_valid && (cnt_q == FW'(OFIFO_DEPTH))));

    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_rd_en        = rd_en;
    assign o_rd_x         = x_q;
    assign o_rd_y         = y_q;
    assign o_k_soft_reset = srst_q;
    assign o_k_weight     = wgt_q;
    assign o_k_valid      = kv_q;
    assign o_k_fmap       = kv_q ? i_rd_data : '0;
    assign o_ot_valid     = cnt_q != '0;
    assign o_ot_data      = (cnt_q != '0) ? mem_q[rp_q] : '0;
endmodule

// File: tb/tb_cnn_kernel_ctrl.sv
// tb_cnn_kernel_ctrl: directed bench with a window-buffer responder, a kernel stand-in and an arithmetic result model.
module tb_cnn_kernel_ctrl;
    localparam int IW = 5, IH = 4, KX = 3, KY = 3, DL = 8, KL = 2, DEPTH = 4;
    localparam int OW = IW - KX + 1, OH = IH - KY + 1, NOUT = OW * OH, NK = KX * KY, VW = NK * DL;

    logic          clk = 1'b0, reset_n = 1'b1;
    logic          i_start = 1'b0, i_abort = 1'b0, i_wgt_we = 1'b0, i_ot_ready = 1'b0;
    logic [VW-1:0] i_wgt_data = '0, i_rd_data = '0;
    logic          o_busy, o_done, o_rd_en, o_k_soft_reset, o_k_valid, o_ot_valid, i_k_valid;
    logic [2:0]    o_rd_x;
    logic [1:0]    o_rd_y;
    logic [VW-1:0] o_k_weight, o_k_fmap;
    logic [DL-1:0] i_k_acc, o_ot_data;

    always #5 clk = ~clk;

    cnn_kernel_ctrl #(.IW(IW), .IH(IH), .KX(KX), .KY(KY), .DATA_LEN(DL), .K_LAT(KL), .OFIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
        .i_wgt_we(i_wgt_we), .i_wgt_data(i_wgt_data), .o_busy(o_busy), .o_done(o_done),
        .o_rd_en(o_rd_en), .o_rd_x(o_rd_x), .o_rd_y(o_rd_y), .i_rd_data(i_rd_data),
        .o_k_soft_reset(o_k_soft_reset), .o_k_weight(o_k_weight), .o_k_valid(o_k_valid),
        .o_k_fmap(o_k_fmap), .i_k_valid(i_k_valid), .i_k_acc(i_k_acc),
        .o_ot_valid(o_ot_valid), .o_ot_data(o_ot_data), .i_ot_ready(i_ot_ready)
    );

    int cmp_n = 0, err_n = 0;
    int iss_n = 0, rd_cnt = 0, pops = 0, done_cnt = 0, cyc = 0, last_pop_cyc = 0, first_val = -1;
    int mode = 0;
    int mw[NK];
    int log_x[NOUT], log_y[NOUT];
    int lit_x[NOUT] = '{0, 1, 2, 0, 1, 2};
    int lit_y[NOUT] = '{0, 0, 0, 1, 1, 1};
    logic [DL-1:0] exp_q[$];
    logic          kp_v[KL];
    logic [DL-1:0] kp_d[KL];

    task automatic check(input string name, input int act, input int exp);
        cmp_n++;
        if (act != exp) begin
            err_n++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Feature map: all ones, or a ramp so each window has a distinct sum.
    function automatic int fm(input int r, input int c);
        return (mode != 0) ? r * IW + c + 1 : 1;
    endfunction

    function automatic logic [VW-1:0] wvec(input int v);
        return {NK{DL'(v)}};
    endfunction

    function automatic logic [VW-1:0] win(input int x, input int y);
        logic [VW-1:0] v = '0;
        for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
                v[(ky * KX + kx) * DL +: DL] = DL'(fm(y + ky, x + kx));
        return v;
    endfunction

    function automatic logic [DL-1:0] dot(input logic [VW-1:0] w, input logic [VW-1:0] f);
        int acc = 0;
        for (int k = 0; k < NK; k++) acc += int'(w[k * DL +: DL]) * int'(f[k * DL +: DL]);
        return DL'(acc);
    endfunction

    // Expected result n of a job: convolution sum at raster position n, truncated to DL bits.
    function automatic logic [DL-1:0] expect_at(input int n);
        int acc = 0;
        for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
                acc += fm(n / OW + ky, n % OW + kx) * mw[ky * KX + kx];
        return DL'(acc);
    endfunction

    always @(posedge clk) if (o_rd_en) i_rd_data <= win(int'(o_rd_x), int'(o_rd_y));

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || o_k_soft_reset) begin
            for (int i = 0; i < KL; i++) begin
                kp_v[i] <= 1'b0;
                kp_d[i] <= '0;
            end
        end else begin
            kp_v[0] <= o_k_valid;
            kp_d[0] <= dot(o_k_weight, o_k_fmap);
            for (int i = 1; i < KL; i++) begin
                kp_v[i] <= kp_v[i-1];
                kp_d[i] <= kp_d[i-1];
            end
        end
    end
    assign i_k_valid = kp_v[KL-1];
    assign i_k_acc   = kp_d[KL-1];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset_n) begin
            if (o_rd_en) begin
                check("rd_in_range", int'(iss_n < NOUT), 1);
                check("rd_x", int'(o_rd_x), iss_n % OW);
                check("rd_y", int'(o_rd_y), iss_n / OW);
                if (iss_n < NOUT) begin
                    log_x[iss_n] = int'(o_rd_x);
                    log_y[iss_n] = int'(o_rd_y);
                end
                iss_n++;
                rd_cnt++;
            end
            if (exp_q.size() == 0) check("ot_valid_idle", int'(o_ot_valid), 0);
            else if (o_ot_valid) begin
                check("ot_data", int'(o_ot_data), int'(exp_q[0]));
                if (i_ot_ready) begin
                    if (pops == 0) first_val = int'(o_ot_data);
                    void'(exp_q.pop_front());
                    pops++;
                    last_pop_cyc = cyc;
                end
            end
            if (o_done) begin
                check("done_all_consumed", exp_q.size(), 0);
                check("done_timing", cyc - last_pop_cyc, 1);
                done_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_rd_en"}, int'(o_rd_en), 0);
        check({tag, "_rd_xy"}, int'({o_rd_x, o_rd_y}), 0);
        check({tag, "_srst"}, int'(o_k_soft_reset), 0);
        check({tag, "_k_valid"}, int'(o_k_valid), 0);
        check({tag, "_ot_valid"}, int'(o_ot_valid), 0);
        check({tag, "_ot_data"}, int'(o_ot_data), 0);
        check({tag, "_weight_zero"}, int'(o_k_weight == '0), 1);
        check({tag, "_fmap_zero"}, int'(o_k_fmap == '0), 1);
    endtask

    task automatic load_w(input int v);
        i_wgt_we = 1'b1;
        i_wgt_data = wvec(v);
        tick(1);
        i_wgt_we = 1'b0;
        for (int k = 0; k < NK; k++) mw[k] = v;
        check("wgt_load", int'(o_k_weight == wvec(v)), 1);
    endtask

    // wv >= 0 loads weights in the same cycle as the start strobe.
    task automatic start_job(input int wv);
        if (wv >= 0) begin
            i_wgt_we = 1'b1;
            i_wgt_data = wvec(wv);
            for (int k = 0; k < NK; k++) mw[k] = wv;
        end
        exp_q.delete();
        for (int n = 0; n < NOUT; n++) exp_q.push_back(expect_at(n));
        iss_n = 0; rd_cnt = 0; pops = 0; done_cnt = 0; first_val = -1;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        i_wgt_we = 1'b0;
        check("clear_srst", int'(o_k_soft_reset), 1);
        check("clear_busy", int'(o_busy), 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_done_seen"}, done_cnt - d0, 1);
    endtask

    task automatic wait_issued(input int target);
        int n = 0;
        while (iss_n < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("issue_reached", int'(iss_n >= target), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < NK; k++) mw[k] = 0;
        #2 reset_n = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick(1);
        check_zero("post_reset");

        // Basic run: ones everywhere, each result is 9.
        mode = 0;
        i_ot_ready = 1'b1;
        load_w(1);
        start_job(-1);
        wait_done("basic");
        tick(5);
        check("basic_pops", pops, NOUT);
        check("basic_first", first_val, 9);
        check("basic_done_once", done_cnt, 1);
        check("basic_idle", int'(o_busy), 0);
        for (int n = 0; n < NOUT; n++) begin
            check("basic_addr_x", log_x[n], lit_x[n]);
            check("basic_addr_y", log_y[n], lit_y[n]);
        end

        // Backpressure on the ramp map: the first window sums to 63.
        mode = 1;
        i_ot_ready = 1'b0;
        start_job(-1);
        tick(20);
        check("bp_reads", rd_cnt, DEPTH);
        check("bp_valid", int'(o_ot_valid), 1);
        check("bp_head", int'(o_ot_data), 63);
        tick(3);
        check("bp_head_stable", int'(o_ot_data), 63);
        check("bp_reads_stalled", rd_cnt, DEPTH);
        i_ot_ready = 1'b1;
        wait_done("bp");
        check("bp_pops", pops, NOUT);

        // Weight lock: a load during RUN is ignored.
        mode = 0;
        load_w(2);
        start_job(-1);
        tick(2);
        i_wgt_we = 1'b1;
        i_wgt_data = wvec(5);
        tick(1);
        i_wgt_we = 1'b0;
        check("lock_run", int'(o_k_weight == wvec(2)), 1);
        wait_done("lock");
        tick(2);
        check("lock_first", first_val, 18);
        check("lock_pops", pops, NOUT);
        check("lock_after", int'(o_k_weight == wvec(2)), 1);

        // Abort in RUN after three issues, then a clean rerun.
        start_job(-1);
        wait_issued(3);
        i_abort = 1'b1;
        tick(1);
        i_abort = 1'b0;
        exp_q.delete();
        check("abort_busy", int'(o_busy), 0);
        check("abort_srst", int'(o_k_soft_reset), 1);
        check("abort_ot_valid", int'(o_ot_valid), 0);
        check("abort_weight", int'(o_k_weight == wvec(2)), 1);
        tick(10);
        check("abort_no_done", done_cnt, 0);
        check("abort_srst_gone", int'(o_k_soft_reset), 0);
        start_job(-1);
        wait_done("rerun");
        tick(2);
        check("rerun_pops", pops, NOUT);
        check("rerun_first", first_val, 18);
        check("rerun_origin", log_x[0] + log_y[0], 0);

        // Weight load and start together, plus starts while busy.
        start_job(3);
        tick(2);
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        wait_issued(NOUT);
        check("busy_drain", int'(o_busy), 1);
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        wait_done("busy");
        tick(10);
        check("busy_done_once", done_cnt, 1);
        check("busy_pops", pops, NOUT);
        check("busy_first", first_val, 27);
        check("busy_idle", int'(o_busy), 0);

        // Asynchronous reset during DRAIN.
        start_job(-1);
        wait_issued(NOUT);
        check("async_in_drain", int'(o_busy), 1);
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1 check_zero("async");
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(3);
        check("async_idle", int'(o_busy), 0);
        check("async_weight", int'(o_k_weight == '0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule

// File: doc/cnn_kernel_ctrl.md
Name: cnn_kernel_ctrl

Overview:
Sequencer for one cnn_kernel instance; performs a full valid-mode, stride-1 convolution of one IW x IH feature map.
- Holds the kernel weights.
- Walks output positions in raster order and reads each KX x KY window from an external window buffer.
- Drives the kernel's valid, fmap and soft-reset inputs.
- Collects kernel results into a small output FIFO with ready/valid backpressure, and signals done when every result has been consumed.

Parameters:
IW, 8, input map width (>= KX)
IH, 8, input map height (>= KY)
KX, 3, kernel width
KY, 3, kernel height
DATA_LEN, 8, element/result width
K_LAT, 2, kernel latency from valid-in to valid-out
OFIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
i_start  in  1  begin a convolution; honoured only in IDLE
i_abort  in  1  abandon current job; honoured in any non-IDLE state
i_wgt_we  in  1  weight load strobe; honoured only in IDLE
i_wgt_data  in  KX*KY*DATA_LEN  weight vector
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse on job completion
o_rd_en  out  1  window read request
o_rd_x  out  clog2(IW)  window top-left column
o_rd_y  out  clog2(IH)  window top-left row
i_rd_data  in  KX*KY*DATA_LEN  window data, valid exactly 1 cycle after o_rd_en
o_k_soft_reset  out  1  to kernel i_soft_reset
o_k_weight  out  KX*KY*DATA_LEN  to kernel i_cnn_weight
o_k_valid  out  1  to kernel i_in_valid
o_k_fmap  out  KX*KY*DATA_LEN  to kernel i_in_fmap
i_k_valid  in  1  from kernel o_ot_valid
i_k_acc  in  DATA_LEN  from kernel o_ot_kernel_acc
o_ot_valid  out  1  result available
o_ot_data  out  DATA_LEN  result value
i_ot_ready  in  1  consumer accepts when valid & ready

Behaviour:
Reset state: all outputs 0, weight register 0, FSM in IDLE, FIFO empty, counters 0.

Derived values:
- OW = IW-KX+1, OH = IH-KY+1, NOUT = OW*OH.

Weights:
- In IDLE, i_wgt_we captures i_wgt_data into o_k_weight on the next edge.
- i_wgt_we is ignored in all other states.

FSM:
- IDLE: i_start -> CLEAR.
- CLEAR: one cycle; o_k_soft_reset=1, x/y/issue/out counters cleared -> RUN.
- RUN: issue reads while issued < NOUT; when the last read issues -> DRAIN.
- DRAIN: wait until popped == NOUT -> DONE.
- DONE: one cycle; o_done=1 -> IDLE.

Issue rule:
- o_rd_en=1 in RUN iff fifo_count + inflight < OFIFO_DEPTH.
- inflight = reads issued whose kernel result has not yet been written to the FIFO; maximum K_LAT+1.
- This credit rule guarantees the FIFO never overflows. A kernel result arriving while the FIFO is full is a design error; assert it in simulation.

Window address:
- o_rd_x/o_rd_y start at (0,0) and advance after each issue.
- x increments; at x==OW-1, x wraps to 0 and y increments.

Kernel drive:
- o_k_valid is o_rd_en delayed by 1 cycle.
- o_k_fmap = i_rd_data, passed through combinationally.
- The first kernel result appears K_LAT+1 cycles after the first o_rd_en.
- With i_ot_ready held 1, throughput is one result per cycle.

Output FIFO:
- Written on i_k_valid with i_k_acc.
- Popped on o_ot_valid & i_ot_ready; o_ot_data is the head entry and is stable while valid & !ready.
- A simultaneous push and pop keeps the count unchanged.
- o_ot_valid = !empty.

Abort (i_abort in CLEAR/RUN/DRAIN/DONE):
- Next state IDLE, FIFO flushed, counters cleared.
- o_k_soft_reset=1 for that one cycle; no o_done pulse; weights retained.
- Abort has priority over all other transitions.

Start:
- i_start while busy is ignored.
- i_start in the same cycle as i_wgt_we in IDLE: the weight is captured and the job starts; the new weight is in use from CLEAR onward.

Counters:
- Widths are clog2(NOUT+1), with no wrap-around.

Asynchronous reset mid-job: returns immediately to the reset state.

Test Plan:
- Basic run: IW=5, IH=4, KX=KY=3; all-ones weights; window buffer returns all-ones; i_ot_ready=1 -> rd addresses (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); 6 results each =9; o_done pulses once, in the cycle after the 6th pop.
- Backpressure: same job with i_ot_ready=0 -> exactly OFIFO_DEPTH=4 o_rd_en pulses then stall; o_ot_data holds the head; raising ready drains in order; total 6 results, no loss or duplication.
- Weight lock: i_wgt_we with 2s in IDLE, start, then i_wgt_we with 5s during RUN -> all results use 2s (=18 on all-ones data); o_k_weight unchanged until back in IDLE.
- Abort: i_abort in RUN after 3 issues -> next cycle IDLE, o_k_soft_reset pulse, o_ot_valid=0, no o_done; a following i_start runs a complete 6-result job from (0,0).
- Start while busy: i_start pulsed in RUN and DRAIN -> ignored; exactly one o_done and 6 results.
- Async reset: drop reset_n mid-DRAIN -> all outputs 0 immediately, FSM IDLE, weights 0.
